// File: rtl/snax_tcdm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snax_tcdm_arb_pkg
// Purpose  : Shared constants and helpers for the SNAX TCDM round-robin
//            arbiter and its in-order response ID FIFO.
// Contents : c_*_DEFAULT   default parameter values for the arbiter
//            id_width()    width of a requester ID ($clog2(n), minimum 1)
// Revision : 1.0 - initial release
// ============================================================================
package snax_tcdm_arb_pkg;

  localparam int unsigned c_NUM_REQ_DEFAULT         = 4;
  localparam int unsigned c_ADDR_WIDTH_DEFAULT      = 32;
  localparam int unsigned c_DATA_WIDTH_DEFAULT      = 32;
  localparam int unsigned c_MAX_OUTSTANDING_DEFAULT = 4;

  // Width of the id_t used to tag requests; a single requester still needs
  // one bit so that vectors never collapse to zero width.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snax_tcdm_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snax_tcdm_arb_id_fifo
// Purpose  : In-order FIFO of requester IDs for requests that are in flight
//            on the shared TCDM port. The head names the requester that owns
//            the next response.
// Ports    : clk_i / rst_ni      clock, asynchronous active-low reset
//            push_i / id_i       enqueue an ID (ignored when full)
//            pop_i               dequeue the head (ignored when empty)
//            full_o / empty_o    status from the registered count
//            head_o              ID at the head of the queue
// Notes    : Depth must be a power of two (>= 2) so pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module snax_tcdm_arb_id_fifo
  import snax_tcdm_arb_pkg::*;
#(
  parameter int unsigned Depth   = c_MAX_OUTSTANDING_DEFAULT,
  parameter int unsigned IdWidth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [IdWidth-1:0] id_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [IdWidth-1:0] head_o
);

  localparam int unsigned c_PTR_W = (Depth <= 1) ? 1 : $clog2(Depth);
  localparam int unsigned c_CNT_W = $clog2(Depth) + 1;

  logic [IdWidth-1:0] r_mem [Depth];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == c_CNT_W'(Depth));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // Full is taken from the registered count: a pop in the same cycle does
  // not make room for a push until the following cycle.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // Storage carries no reset; entries are only read when the count says
  // they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/snax_tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snax_tcdm_rr_arbiter
// Purpose  : Round-robin arbiter that shares one TCDM port between NumReq
//            requesters. Requests pass through combinationally; a stalled
//            grant is locked until accepted. Responses return in order and
//            are routed back using an ID FIFO.
// Ports    : clk_i, rst_ni                     clock, async active-low reset
//            req_q_valid_i / req_q_ready_o     per-requester request handshake
//            req_addr_i/write_i/data_i/strb_i  flattened request payloads
//            req_p_valid_o / req_p_data_o      per-requester response strobe,
//                                              broadcast response data
//            mst_q_valid_o / mst_q_ready_i     shared-port request handshake
//            mst_addr_o/write_o/data_o/strb_o  selected payload
//            mst_p_valid_i / mst_p_data_i      shared-port in-order response
// Option   : SNAX_TCDM_ARB_PERF_EN adds perf_grant_o (32-bit grant count per
//            requester, flattened) and perf_stall_o (cycles with a pending
//            request but no handshake). Both counters wrap.
// Revision : 1.0 - initial release
// ============================================================================
module snax_tcdm_rr_arbiter
  import snax_tcdm_arb_pkg::*;
#(
  parameter int unsigned NumReq         = c_NUM_REQ_DEFAULT,
  parameter int unsigned AddrWidth      = c_ADDR_WIDTH_DEFAULT,
  parameter int unsigned DataWidth      = c_DATA_WIDTH_DEFAULT,
  parameter int unsigned MaxOutstanding = c_MAX_OUTSTANDING_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_q_valid_i,
  output logic [NumReq-1:0]                 req_q_ready_o,
  input  logic [NumReq*AddrWidth-1:0]       req_addr_i,
  input  logic [NumReq-1:0]                 req_write_i,
  input  logic [NumReq*DataWidth-1:0]       req_data_i,
  input  logic [NumReq*(DataWidth/8)-1:0]   req_strb_i,
  output logic [NumReq-1:0]                 req_p_valid_o,
  output logic [DataWidth-1:0]              req_p_data_o,
  output logic                              mst_q_valid_o,
  input  logic                              mst_q_ready_i,
  output logic [AddrWidth-1:0]              mst_addr_o,
  output logic                              mst_write_o,
  output logic [DataWidth-1:0]              mst_data_o,
  output logic [DataWidth/8-1:0]            mst_strb_o,
  input  logic                              mst_p_valid_i,
  input  logic [DataWidth-1:0]              mst_p_data_i
`ifdef SNAX_TCDM_ARB_PERF_EN
  ,
  output logic [NumReq*32-1:0]              perf_grant_o,
  output logic [31:0]                       perf_stall_o
`endif
);

  localparam int unsigned c_ID_W   = id_width(NumReq);
  localparam int unsigned c_STRB_W = DataWidth / 8;

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  logic [c_ID_W-1:0] r_rr_ptr;
  logic              r_lock;
  logic [c_ID_W-1:0] r_lock_sel;

  logic [c_ID_W-1:0] w_hi_sel;
  logic              w_hi_found;
  logic [c_ID_W-1:0] w_lo_sel;
  logic              w_lo_found;
  logic [c_ID_W-1:0] w_arb_sel;
  logic [c_ID_W-1:0] w_sel;
  logic              w_hs;

  // ID FIFO status
  logic              w_full;
  logic              w_empty;
  logic [c_ID_W-1:0] w_head;
  logic              w_resp;

  // Scan from the top down so the last hit is the lowest index. w_hi_*
  // tracks the lowest valid index at or above the pointer; w_lo_* the lowest
  // valid index overall, used when the search has to wrap.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_found = 1'b0;
    w_lo_sel   = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_q_valid_i[i]) begin
        w_lo_found = 1'b1;
        w_lo_sel   = c_ID_W'(i);
        if (c_ID_W'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_sel   = c_ID_W'(i);
        end
      end
    end
  end

  // With no request pending the choice is irrelevant; parking on the
  // pointer keeps the selection stable.
  always_comb begin
    w_arb_sel = r_rr_ptr;
    if (w_hi_found) begin
      w_arb_sel = w_hi_sel;
    end else if (w_lo_found) begin
      w_arb_sel = w_lo_sel;
    end
  end

  assign w_sel = r_lock ? r_lock_sel : w_arb_sel;

  // --------------------------------------------------------------------------
  // Request path (zero latency). Reset gates the handshake outputs because
  // they are combinational from the requesters.
  // --------------------------------------------------------------------------
  assign mst_q_valid_o = rst_ni & ~w_full & req_q_valid_i[w_sel];
  assign w_hs          = mst_q_valid_o & mst_q_ready_i;

  always_comb begin
    req_q_ready_o        = '0;
    req_q_ready_o[w_sel] = rst_ni & mst_q_ready_i & ~w_full;
  end

  always_comb begin
    mst_addr_o  = req_addr_i[int'(w_sel)*AddrWidth +: AddrWidth];
    mst_write_o = req_write_i[w_sel];
    mst_data_o  = req_data_i[int'(w_sel)*DataWidth +: DataWidth];
    mst_strb_o  = req_strb_i[int'(w_sel)*c_STRB_W +: c_STRB_W];
  end

  // Lock holds the grant while the port stalls so the payload cannot change
  // under a pending request; the pointer only moves on acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= '0;
    end else begin
      if (w_hs) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= (w_sel == c_ID_W'(NumReq - 1)) ? '0 : w_sel + 1'b1;
      end else if (mst_q_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response path: the head of the ID FIFO owns the current response.
  // --------------------------------------------------------------------------
  snax_tcdm_arb_id_fifo #(
    .Depth   (MaxOutstanding),
    .IdWidth (c_ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_hs),
    .id_i    (w_sel),
    .pop_i   (w_resp),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // A response with nothing outstanding (e.g. one that was in flight across
  // a reset) has no owner and is dropped.
  assign w_resp = mst_p_valid_i & ~w_empty;

  always_comb begin
    req_p_valid_o = '0;
    if (w_resp) begin
      req_p_valid_o[w_head] = 1'b1;
    end
  end

  assign req_p_data_o = mst_p_data_i;

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef SNAX_TCDM_ARB_PERF_EN
  logic [31:0] r_perf_grant [NumReq];
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumReq); i++) begin
        r_perf_grant[i] <= '0;
      end
      r_perf_stall <= '0;
    end else begin
      if (w_hs) begin
        r_perf_grant[w_sel] <= r_perf_grant[w_sel] + 32'd1;
      end
      if ((|req_q_valid_i) && !w_hs) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < int'(NumReq); g++) begin : g_perf_out
    assign perf_grant_o[g*32 +: 32] = r_perf_grant[g];
  end

  assign perf_stall_o = r_perf_stall;
`endif

  // --------------------------------------------------------------------------
  // Protocol checks (simulation only)
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      a_resp_without_owner: assert (!(mst_p_valid_i && w_empty))
        else $warning("snax_tcdm_rr_arbiter: response with no outstanding request dropped");
      a_locked_valid_held: assert (!(r_lock && !req_q_valid_i[r_lock_sel]))
        else $error("snax_tcdm_rr_arbiter: locked requester dropped its request valid");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_snax_tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snax_tcdm_rr_arbiter
// Purpose  : Self-checking bench for snax_tcdm_rr_arbiter (NumReq=4,
//            MaxOutstanding=2). A queue-based reference model is compared
//            against the DUT on every falling edge; directed scenarios add
//            hand-computed literal expectations.
// Option   : SNAX_TCDM_ARB_PERF_EN enables the performance counter scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snax_tcdm_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   valid;
  logic [NR-1:0]   q_ready_o;
  logic [NR*AW-1:0] addr;
  logic [NR-1:0]   write;
  logic [NR*DW-1:0] wdata;
  logic [NR*4-1:0] strb;
  logic [NR-1:0]   p_valid_o;
  logic [DW-1:0]   p_data_o;
  logic            m_valid;
  logic            m_ready;
  logic [AW-1:0]   m_addr;
  logic            m_write;
  logic [DW-1:0]   m_data;
  logic [3:0]      m_strb;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
`ifdef SNAX_TCDM_ARB_PERF_EN
  logic [NR*32-1:0] perf_grant;
  logic [31:0]      perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  snax_tcdm_rr_arbiter #(
    .NumReq         (NR),
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_q_valid_i (valid),
    .req_q_ready_o (q_ready_o),
    .req_addr_i    (addr),
    .req_write_i   (write),
    .req_data_i    (wdata),
    .req_strb_i    (strb),
    .req_p_valid_o (p_valid_o),
    .req_p_data_o  (p_data_o),
    .mst_q_valid_o (m_valid),
    .mst_q_ready_i (m_ready),
    .mst_addr_o    (m_addr),
    .mst_write_o   (m_write),
    .mst_data_o    (m_data),
    .mst_strb_o    (m_strb),
    .mst_p_valid_i (rsp_valid),
    .mst_p_data_i  (rsp_data)
`ifdef SNAX_TCDM_ARB_PERF_EN
    ,
    .perf_grant_o  (perf_grant),
    .perf_stall_o  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: round-robin pointer, held grant while stalled, and a
  // queue of owners for in-flight requests.
  // --------------------------------------------------------------------------
  int m_ptr    = 0;
  bit m_locked = 0;
  int m_held   = 0;
  int m_q[$];

  function automatic int pick();
    if (m_locked) return m_held;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (valid[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int  g;
    bit  full;
    bit  e_mv;
    logic [3:0] e_rdy;
    logic [3:0] e_pv;
    if (!rst_n) begin
      m_ptr    = 0;
      m_locked = 0;
      m_held   = 0;
      m_q.delete();
      chk("model_rst_mst_valid", {31'b0, m_valid}, 32'd0);
      chk("model_rst_q_ready", {28'b0, q_ready_o}, 32'd0);
      chk("model_rst_p_valid", {28'b0, p_valid_o}, 32'd0);
    end else begin
      g     = pick();
      full  = (m_q.size() >= MO);
      e_mv  = (g >= 0) && valid[g] && !full;
      chk("model_mst_valid", {31'b0, m_valid}, {31'b0, e_mv});
      if (g >= 0) begin
        e_rdy = (m_ready && !full) ? 4'(1 << g) : 4'b0;
        chk("model_q_ready", {28'b0, q_ready_o}, {28'b0, e_rdy});
      end
      if (e_mv) begin
        chk("model_mst_addr", m_addr, addr[g*AW +: AW]);
        chk("model_mst_write", {31'b0, m_write}, {31'b0, write[g]});
        chk("model_mst_data", m_data, wdata[g*DW +: DW]);
        chk("model_mst_strb", {28'b0, m_strb}, {28'b0, strb[g*4 +: 4]});
      end
      e_pv = (rsp_valid && m_q.size() > 0) ? 4'(1 << m_q[0]) : 4'b0;
      chk("model_p_valid", {28'b0, p_valid_o}, {28'b0, e_pv});
      if (e_pv != 4'b0) chk("model_p_data", p_data_o, rsp_data);
      // State as it will be after the coming rising edge
      if (rsp_valid && m_q.size() > 0) void'(m_q.pop_front());
      if (e_mv && m_ready) begin
        m_q.push_back(g);
        m_ptr    = (g + 1) % NR;
        m_locked = 0;
      end else if (e_mv) begin
        m_locked = 1;
        m_held   = g;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus: each call advances one cycle, applies inputs just
  // after the rising edge and returns at the falling edge for sampling.
  // --------------------------------------------------------------------------
  task automatic drive(input logic [3:0] v, input logic r, input logic pv, input logic [31:0] pd);
    @(posedge clk);
    #1;
    valid     = v;
    m_ready   = r;
    rsp_valid = pv;
    rsp_data  = pd;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    valid     = '0;
    m_ready   = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    for (int i = 0; i < NR; i++) begin
      addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i) * 32'h100;
      wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      strb[i*4 +: 4]    = 4'(i + 1);
      write[i]          = i[0];
    end

    // Reset: requests present but every handshake output must stay low
    drive(4'hF, 1'b1, 1'b0, 32'h0);
    chk("rst_mst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_q_ready", {28'b0, q_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = '0;

    // All four requesting, port always ready: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 1'b1, k >= 1, 32'hB000_0000 + 32'(k));
      chk("rr_grant", {28'b0, q_ready_o}, 32'(1 << (k % 4)));
      if (k >= 1) chk("rr_resp", {28'b0, p_valid_o}, 32'(1 << (k - 1)));
    end
    drive(4'b0010, 1'b1, 1'b1, 32'h0);
    chk("rr_tail_resp", {28'b0, p_valid_o}, 32'h1);
    chk("rr_tail_grant", {28'b0, q_ready_o}, 32'h2);
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("rr_drain_resp", {28'b0, p_valid_o}, 32'h2);

    // Stall lock: pointer at 2, req1 alone stalls, req0 joins in cycle 2
    drive(4'b0010, 1'b0, 1'b0, 32'h0);
    chk("lock_c1_valid", {31'b0, m_valid}, 32'd1);
    chk("lock_c1_addr", m_addr, 32'h1000_0100);
    chk("lock_c1_ready", {28'b0, q_ready_o}, 32'd0);
    drive(4'b0011, 1'b0, 1'b0, 32'h0);
    chk("lock_c2_addr", m_addr, 32'h1000_0100);
    drive(4'b0011, 1'b0, 1'b0, 32'h0);
    chk("lock_c3_addr", m_addr, 32'h1000_0100);
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    chk("lock_c4_ready", {28'b0, q_ready_o}, 32'h2);
    chk("lock_c4_addr", m_addr, 32'h1000_0100);
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    chk("lock_next_grant", {28'b0, q_ready_o}, 32'h1);
    chk("lock_next_addr", m_addr, 32'h1000_0000);
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("lock_resp1", {28'b0, p_valid_o}, 32'h2);
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("lock_resp0", {28'b0, p_valid_o}, 32'h1);

    // Full FIFO: pointer at 1
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    chk("full_push1", {28'b0, q_ready_o}, 32'h2);
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    chk("full_push2", {28'b0, q_ready_o}, 32'h4);
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    chk("full_mst_valid", {31'b0, m_valid}, 32'd0);
    chk("full_q_ready", {28'b0, q_ready_o}, 32'd0);
    drive(4'b1000, 1'b1, 1'b1, 32'h0);
    chk("full_pop_mst_valid", {31'b0, m_valid}, 32'd0);
    chk("full_pop_q_ready", {28'b0, q_ready_o}, 32'd0);
    chk("full_pop_resp", {28'b0, p_valid_o}, 32'h2);
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    chk("full_after_valid", {31'b0, m_valid}, 32'd1);
    chk("full_after_ready", {28'b0, q_ready_o}, 32'h8);
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("full_drain2", {28'b0, p_valid_o}, 32'h4);
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("full_drain3", {28'b0, p_valid_o}, 32'h8);

    // In-order routing: pointer at 0, req2 read then req0 read
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    chk("route_grant2", {28'b0, q_ready_o}, 32'h4);
    chk("route_read2", {31'b0, m_write}, 32'd0);
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    chk("route_grant0", {28'b0, q_ready_o}, 32'h1);
    drive(4'b0000, 1'b0, 1'b1, 32'hA5A5_0001);
    chk("route_pv2", {28'b0, p_valid_o}, 32'h4);
    chk("route_pd2", p_data_o, 32'hA5A5_0001);
    drive(4'b0000, 1'b0, 1'b1, 32'hA5A5_0002);
    chk("route_pv0", {28'b0, p_valid_o}, 32'h1);
    chk("route_pd0", p_data_o, 32'hA5A5_0002);

    // Reset with two outstanding: pointer at 1
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    chk("mrst_fill", {28'b0, q_ready_o}, 32'h4);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    valid   = 4'hF;
    m_ready = 1'b1;
    @(negedge clk);
    chk("mrst_mst_valid", {31'b0, m_valid}, 32'd0);
    chk("mrst_q_ready", {28'b0, q_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    valid     = 4'b0000;
    m_ready   = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_0001;
    @(negedge clk);
    chk("mrst_orphan_resp", {28'b0, p_valid_o}, 32'd0);
    drive(4'b1001, 1'b1, 1'b0, 32'h0);
    chk("mrst_first_grant", {28'b0, q_ready_o}, 32'h1);
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("mrst_resp0", {28'b0, p_valid_o}, 32'h1);

`ifdef SNAX_TCDM_ARB_PERF_EN
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b1000, 1'b0, 1'b0, 32'h0);
    drive(4'b1000, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(4'b1000, 1'b1, k >= 1, 32'h0);
    end
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    chk("perf_grant3", perf_grant[3*32 +: 32], 32'd5);
    chk("perf_grant0", perf_grant[0 +: 32], 32'd0);
    chk("perf_stall", perf_stall, 32'd2);
`endif

    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
